// File: rtl/pwm_knn_rank_if.sv
// rtl/pwm_knn_rank_if.sv - control, PWM and result bundle for the k-NN rank unit
interface pwm_knn_rank_if #(
    parameter int N_CH  = 8,
    parameter int CNT_W = 12,
    parameter int TO_W  = 16
);
    localparam int KW = $clog2(N_CH + 1);
    localparam int RW = $clog2(N_CH);

    logic                  i_start;
    logic [KW-1:0]         i_k;
    logic [N_CH-1:0]       i_en_mask;
    logic [TO_W-1:0]       i_to_cycles;
    logic [N_CH-1:0]       i_pwm;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_timeout;
    logic [N_CH-1:0]       o_nn;
    logic [N_CH-1:0]       o_knn;
    logic [KW-1:0]         o_fall_cnt;
    logic [N_CH*CNT_W-1:0] o_count;
    logic [N_CH*RW-1:0]    o_rank;
    logic [N_CH-1:0]       o_fin;

    modport master (
        output i_start, i_k, i_en_mask, i_to_cycles, i_pwm,
        input  o_busy, o_done, o_timeout, o_nn, o_knn, o_fall_cnt, o_count, o_rank, o_fin
    );
    modport slave (
        input  i_start, i_k, i_en_mask, i_to_cycles, i_pwm,
        output o_busy, o_done, o_timeout, o_nn, o_knn, o_fall_cnt, o_count, o_rank, o_fin
    );
endinterface

// File: rtl/pwm_knn_rank.sv
// rtl/pwm_knn_rank.sv - PWM high-time measurement and falling-edge k-NN ranking
// Optional epoch timeout compiled in with KNN_TIMEOUT_EN.
module pwm_knn_rank #(
    parameter int N_CH  = 8,
    parameter int CNT_W = 12,
    parameter int TO_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    pwm_knn_rank_if.slave     bus
);
    localparam int KW = $clog2(N_CH + 1);
    localparam int RW = $clog2(N_CH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t state, state_nxt;

    logic [N_CH-1:0]            sync1, sync2, prev;
    logic [KW-1:0]              k_lat, fall_cnt, fall_nxt;
    logic [N_CH-1:0]            en_lat, fin, fin_nxt, knn, knn_nxt, nn, nn_nxt, act_fall;
    logic [N_CH-1:0][CNT_W-1:0] cnt;
    logic [N_CH-1:0][RW-1:0]    rank, rank_nxt;
    logic                       run, norm_end, to_end, busy, done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= bus.i_pwm;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign run      = (state == S_RUN);
    assign act_fall = prev & ~sync2 & en_lat & ~fin & {N_CH{run}};

    // Simultaneous falls take consecutive ranks, lowest index first.
    always_comb begin
        fall_nxt = fall_cnt;
        rank_nxt = rank;
        fin_nxt  = fin;
        knn_nxt  = knn;
        nn_nxt   = nn;
        for (int i = 0; i < N_CH; i++) begin
            if (act_fall[i]) begin
                rank_nxt[i] = fall_nxt[RW-1:0];
                fin_nxt[i]  = 1'b1;
                if (fall_nxt < k_lat) knn_nxt[i] = 1'b1;
                if (fall_nxt == '0 && k_lat != '0) nn_nxt[i] = 1'b1;
                fall_nxt = fall_nxt + KW'(1);
            end
        end
    end

    assign norm_end = (fall_nxt >= k_lat) || ((fin_nxt & en_lat) == en_lat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.i_start) begin
            state_nxt = S_RUN;
        end else begin
            case (state)
                S_RUN:   if (norm_end || to_end) state_nxt = S_DONE;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_lat    <= '0;
            en_lat   <= '0;
            fall_cnt <= '0;
            fin      <= '0;
            knn      <= '0;
            nn       <= '0;
            cnt      <= '0;
            rank     <= '0;
        end else if (bus.i_start) begin
            k_lat    <= bus.i_k;
            en_lat   <= bus.i_en_mask;
            fall_cnt <= '0;
            fin      <= '0;
            knn      <= '0;
            nn       <= '0;
            cnt      <= '0;
            rank     <= '0;
        end else if (run) begin
            fall_cnt <= fall_nxt;
            fin      <= fin_nxt;
            knn      <= knn_nxt;
            nn       <= nn_nxt;
            rank     <= rank_nxt;
            for (int i = 0; i < N_CH; i++) begin
                if (en_lat[i] && !fin[i] && sync2[i] && cnt[i] != {CNT_W{1'b1}})
                    cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end

`ifdef KNN_TIMEOUT_EN
    logic [TO_W-1:0] to_lat, to_cnt;
    logic            to_flag;

    // A limit of zero never matches, which disables the timeout.
    assign to_end = (to_lat != '0) && ((to_cnt + TO_W'(1)) == to_lat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_lat  <= '0;
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else if (bus.i_start) begin
            to_lat  <= bus.i_to_cycles;
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else if (run) begin
            to_cnt <= to_cnt + TO_W'(1);
            if (to_end && !norm_end) to_flag <= 1'b1;
        end
    end

    assign bus.o_timeout = to_flag;
`else
    logic unused_to;
    assign unused_to     = ^bus.i_to_cycles;
    assign to_end        = 1'b0;
    assign bus.o_timeout = 1'b0;
`endif

    assign bus.o_busy     = busy;
    assign bus.o_done     = done;
    assign bus.o_nn       = nn;
    assign bus.o_knn      = knn;
    assign bus.o_fall_cnt = fall_cnt;
    assign bus.o_count    = cnt;
    assign bus.o_rank     = rank;
    assign bus.o_fin      = fin;
endmodule
